cache_way_array: RTL and testbench

- Multi-way cache storage array for L1 I/D caches: NUM_WAYS independent ways share one set index.
- Per-way write enable and per-byte write mask; synchronous registered read with valid strobe.
- After reset, a sequential init engine zeroes every set, one set per cycle, instead of using a wide single-cycle clear.
- Holds data lines, or tag/valid/dirty fields when WIDTH is narrow.

---
 rtl/cache_way_array_pkg.sv | 18 +
 rtl/cache_way_array_if.sv | 27 ++
 rtl/cache_way_array_bank.sv | 37 +++
 rtl/cache_way_array.sv | 137 +++++++++++++
 tb/tb_cache_way_array.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_way_array_pkg.sv
// Shared types and helpers for the cache way array: FSM state encoding and
// the byte-merge function used by both the storage write path and the
// same-cycle read forward path.
package cache_array_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } array_state_e;

  // One byte of a masked write: take the new byte when its enable is set.
  function automatic logic [7:0] mask_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       mask);
    return mask ? new_b : old_b;
  endfunction

endpackage

// File: rtl/cache_way_array_if.sv
// Request/response bundle between a cache controller (master) and the
// way array (slave): one read port, one shared write port, init status.
interface cache_way_array_if #(
  parameter int S_INDEX  = 4,
  parameter int WIDTH    = 256,
  parameter int NUM_WAYS = 2
);
  logic                      init_done;
  logic                      rd_en;
  logic [S_INDEX-1:0]        rindex;
  logic                      rvalid;
  logic [NUM_WAYS*WIDTH-1:0] rdata;
  logic [NUM_WAYS-1:0]       wr_en;
  logic [S_INDEX-1:0]        windex;
  logic [WIDTH/8-1:0]        wmask;
  logic [WIDTH-1:0]          wdata;

  modport master (
    input  init_done, rvalid, rdata,
    output rd_en, rindex, wr_en, windex, wmask, wdata
  );

  modport slave (
    output init_done, rvalid, rdata,
    input  rd_en, rindex, wr_en, windex, wmask, wdata
  );
endinterface

// File: rtl/cache_way_array_bank.sv
// One way of the cache array: NUM_SETS lines of WIDTH bits with byte-masked
// write. Read is a plain combinational lookup; the top level registers it.
module cache_way_bank
  import cache_array_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 256
) (
  input  logic               clk,
  input  logic               we,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [S_INDEX-1:0] rindex,
  output logic [WIDTH-1:0]   rline
);
  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [WIDTH-1:0] mem [NUM_SETS];
  logic [WIDTH-1:0] merged;

  // Build the post-write line: masked bytes from wdata, the rest kept.
  always_comb begin
    merged = mem[windex];
    for (int b = 0; b < WIDTH / 8; b++) begin
      merged[b*8 +: 8] = mask_merge(mem[windex][b*8 +: 8], wdata[b*8 +: 8], wmask[b]);
    end
  end

  // Storage update; contents are cleared by the init engine, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[windex] <= merged;
  end

  assign rline = mem[rindex];

endmodule

// File: rtl/cache_way_array.sv
// Multi-way cache storage array with sequential post-reset clear engine,
// per-way/per-byte write and one-cycle registered read.
// Optional macro CACHE_ARRAY_WRITE_FORWARD_EN: a read and write to the same
// set in the same cycle returns the merged (post-write) line for written
// ways; when undefined the read sees pre-write contents.
module cache_way_array
  import cache_array_pkg::*;
#(
  parameter int S_INDEX  = 4,
  parameter int WIDTH    = 256,
  parameter int NUM_WAYS = 2
) (
  input logic               clk,
  input logic               rst,
  cache_way_array_if.slave  bus
);
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX:0] LAST_SET = (S_INDEX + 1)'(NUM_SETS - 1);

  array_state_e              state;
  array_state_e              state_nxt;
  logic [S_INDEX:0]          cnt;
  logic                      init_wr;
  logic                      init_done;

  logic [NUM_WAYS-1:0]       bank_we;
  logic [S_INDEX-1:0]        bank_windex;
  logic [WIDTH/8-1:0]        bank_wmask;
  logic [WIDTH-1:0]          bank_wdata;

  logic [NUM_WAYS*WIDTH-1:0] rd_line;
  logic [NUM_WAYS*WIDTH-1:0] rd_next;
  logic                      rd_acc;
  logic [NUM_WAYS*WIDTH-1:0] rdata_p1;
  logic                      vld_p1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Leave INIT after the last set has been cleared; READY is terminal.
  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == LAST_SET) state_nxt = READY;
  end

  // FSM outputs: the clear engine writes while in INIT.
  always_comb begin
    init_wr = (state == INIT);
  end

  // Init counter: one extra bit so the terminal set needs no wrap logic.
  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (init_wr) cnt <= cnt + 1'b1;
  end

  // init_done trails the READY transition by one edge.
  always_ff @(posedge clk) begin
    if (rst) init_done <= 1'b0;
    else     init_done <= (state == READY);
  end

  // Write port mux: clear engine owns the banks until init completes.
  always_comb begin
    if (init_wr) begin
      bank_we     = '1;
      bank_windex = cnt[S_INDEX-1:0];
      bank_wmask  = '1;
      bank_wdata  = '0;
    end else begin
      bank_we     = init_done ? bus.wr_en : '0;
      bank_windex = bus.windex;
      bank_wmask  = bus.wmask;
      bank_wdata  = bus.wdata;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_way_bank #(
      .S_INDEX (S_INDEX),
      .WIDTH   (WIDTH)
    ) u_bank (
      .clk    (clk),
      .we     (bank_we[w]),
      .windex (bank_windex),
      .wmask  (bank_wmask),
      .wdata  (bank_wdata),
      .rindex (bus.rindex),
      .rline  (rd_line[w*WIDTH +: WIDTH])
    );
  end

  assign rd_acc = bus.rd_en & init_done;

  // Read data selection, optionally forwarding a same-set write.
  always_comb begin
    rd_next = rd_line;
`ifdef CACHE_ARRAY_WRITE_FORWARD_EN
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (init_done && bus.wr_en[w] && (bus.windex == bus.rindex)) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
          rd_next[w*WIDTH + b*8 +: 8] = mask_merge(rd_line[w*WIDTH + b*8 +: 8],
                                                   bus.wdata[b*8 +: 8], bus.wmask[b]);
        end
      end
    end
`endif
  end

  // ---- stage p1: registered read; rdata holds between accepted reads ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= rd_next;
    end
  end

  assign bus.init_done = init_done;
  assign bus.rvalid    = vld_p1;
  assign bus.rdata     = rdata_p1;

`ifndef SYNTHESIS
  // Parameter sanity and early-request notice.
  always @(posedge clk) begin
    assert (WIDTH % 8 == 0) else $error("cache_way_array: WIDTH must be a multiple of 8");
    if (!rst && !init_done && (bus.rd_en || (|bus.wr_en)))
      $warning("cache_way_array: request ignored while init in progress");
  end
`endif

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array (defaults: 16 sets, 256-bit, 2 ways).
module tb_cache_way_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cache_way_array_if #(.S_INDEX(4), .WIDTH(256), .NUM_WAYS(2)) bus ();

  cache_way_array #(.S_INDEX(4), .WIDTH(256), .NUM_WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [1:0] we, input logic [3:0] idx,
                            input logic [31:0] m, input logic [255:0] d);
    bus.wr_en  = we;
    bus.windex = idx;
    bus.wmask  = m;
    bus.wdata  = d;
    tick();
    bus.wr_en  = 2'b00;
    bus.wmask  = '0;
  endtask

  task automatic read_line(input logic [3:0] idx, output logic [511:0] line, output logic v);
    bus.rd_en  = 1'b1;
    bus.rindex = idx;
    tick();
    v          = bus.rvalid;
    line       = bus.rdata;
    bus.rd_en  = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!bus.init_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int   n;
    logic seen;
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b want=0", bus.init_done); end
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", bus.rvalid); end
    total++; if (bus.rdata !== 512'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    rst        = 1'b0;
    bus.rd_en  = 1'b1;
    bus.rindex = 4'd0;
    n    = 0;
    seen = 1'b0;
    while (!bus.init_done && n < 40) begin
      tick();
      n++;
      if (bus.rvalid) seen = 1'b1;
    end
    bus.rd_en = 1'b0;
    total++; if (n != 17) begin bad++; $display("FAIL init_latency got=%0d want=17", n); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL init_rvalid got=%b want=0", seen); end
  endtask

  task automatic test_init_zero();
    logic [511:0] line;
    logic         v;
    for (int i = 0; i < 16; i++) begin
      read_line(4'(i), line, v);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL zero_rvalid idx=%0d got=%b want=1", i, v); end
      total++; if (line !== 512'h0) begin bad++; $display("FAIL zero_data idx=%0d got=%h want=0", i, line); end
    end
  endtask

  task automatic test_byte_write();
    logic [511:0] line;
    logic         v;
    write_line(2'b01, 4'd5, 32'h0000_000F, 256'hA3A2A1A0);
    read_line(4'd5, line, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL bytewr_rvalid got=%b want=1", v); end
    total++; if (line !== {256'h0, 256'hA3A2A1A0}) begin bad++; $display("FAIL bytewr_data got=%h want=%h", line, {256'h0, 256'hA3A2A1A0}); end
    tick();
    total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL bytewr_rvalid_drop got=%b want=0", bus.rvalid); end
  endtask

  task automatic test_top_index();
    logic [511:0] line;
    logic         v;
    logic [255:0] wd;
    wd = {8{32'hDEADBEEF}};
    write_line(2'b11, 4'd15, 32'hFFFF_FFFF, wd);
    read_line(4'd15, line, v);
    total++; if (line !== {wd, wd} || v !== 1'b1) begin bad++; $display("FAIL top_index v=%b got=%h want=%h", v, line, {wd, wd}); end
    read_line(4'd14, line, v);
    total++; if (line !== 512'h0 || v !== 1'b1) begin bad++; $display("FAIL below_top v=%b got=%h want=0", v, line); end
  endtask

  task automatic test_same_index();
    logic [511:0] line;
    logic         v;
    logic [7:0]   exp_b0;
`ifdef CACHE_ARRAY_WRITE_FORWARD_EN
    exp_b0 = 8'hFF;
`else
    exp_b0 = 8'h00;
`endif
    bus.wr_en  = 2'b01;
    bus.windex = 4'd3;
    bus.wmask  = 32'h0000_0001;
    bus.wdata  = 256'hFF;
    bus.rd_en  = 1'b1;
    bus.rindex = 4'd3;
    tick();
    bus.wr_en = 2'b00;
    bus.wmask = '0;
    bus.rd_en = 1'b0;
    total++; if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL same_rvalid got=%b want=1", bus.rvalid); end
    total++; if (bus.rdata[7:0] !== exp_b0) begin bad++; $display("FAIL same_byte0 got=%h want=%h", bus.rdata[7:0], exp_b0); end
    total++; if (bus.rdata[511:8] !== 504'h0) begin bad++; $display("FAIL same_rest got=%h want=0", bus.rdata[511:8]); end
    read_line(4'd3, line, v);
    total++; if (line !== 512'hFF || v !== 1'b1) begin bad++; $display("FAIL same_after v=%b got=%h want=ff", v, line); end
  endtask

  task automatic test_rdata_hold();
    logic [511:0] line;
    logic         v;
    read_line(4'd5, line, v);
    total++; if (line !== {256'h0, 256'hA3A2A1A0}) begin bad++; $display("FAIL hold_first got=%h want=a3a2a1a0", line); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL hold_rvalid cyc=%0d got=%b want=0", i, bus.rvalid); end
      total++; if (bus.rdata !== {256'h0, 256'hA3A2A1A0}) begin bad++; $display("FAIL hold_data cyc=%0d got=%h want=a3a2a1a0", i, bus.rdata); end
    end
  endtask

  task automatic test_reset_mid_init();
    logic [511:0] line;
    logic         v;
    int           n;
    logic [255:0] wd;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL mid_init_done got=%b want=0", bus.init_done); end
    rst = 1'b1;
    tick();
    total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", bus.init_done); end
    rst = 1'b0;
    wait_init(n);
    total++; if (n != 17) begin bad++; $display("FAIL mid_restart_latency got=%0d want=17", n); end
    wd = {8{32'h12345678}};
    write_line(2'b11, 4'd2, 32'hFFFF_FFFF, wd);
    read_line(4'd2, line, v);
    total++; if (line !== {wd, wd}) begin bad++; $display("FAIL pre_rst_idx2 got=%h want=%h", line, {wd, wd}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n);
    total++; if (n != 17) begin bad++; $display("FAIL reinit_latency got=%0d want=17", n); end
    read_line(4'd2, line, v);
    total++; if (line !== 512'h0 || v !== 1'b1) begin bad++; $display("FAIL post_rst_idx2 v=%b got=%h want=0", v, line); end
    read_line(4'd15, line, v);
    total++; if (line !== 512'h0) begin bad++; $display("FAIL post_rst_idx15 got=%h want=0", line); end
  endtask

  initial begin
    bus.rd_en  = 1'b0;
    bus.rindex = '0;
    bus.wr_en  = '0;
    bus.windex = '0;
    bus.wmask  = '0;
    bus.wdata  = '0;
    test_reset();
    test_init_zero();
    test_byte_write();
    test_top_index();
    test_same_index();
    test_rdata_hold();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
